// File: rtl/salu_operand_sequencer.sv
// Scalar operand sequencer: reads SGPR operands, hands them to the SALU and
// writes the result back, suppressing writes to read-only SGPR addresses.
module salu_operand_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ADDR_W-1:0] src0_addr,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              is_64,
    input  logic              wr_req,
    output logic [ADDR_W-1:0] rf_s0,
    output logic [ADDR_W-1:0] rf_s1,
    input  logic [DATA_W-1:0] rf_r0,
    input  logic [DATA_W-1:0] rf_r1,
    output logic              op_valid,
    output logic [DATA_W-1:0] op0,
    output logic [DATA_W-1:0] op1,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] rf_w0,
    output logic [DATA_W-1:0] rf_wv,
    output logic              rf_en_w,
    output logic              rf_en_64,
    output logic              wr_fault,
    output logic              busy
);
    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        rd_cnt;
    logic [ADDR_W-1:0] dst_q;
    logic              is64_q;
    logic              wr_q;
    logic              dst_prot;

    function automatic logic prot_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(8'h7D)) ||
               (a >= ADDR_W'(8'h80) && a <= ADDR_W'(8'hE8)) ||
               (a >= ADDR_W'(8'hF0) && a <= ADDR_W'(8'hF8));
    endfunction

    // The top SGPR has no partner, so a 64-bit read of it returns zero upper bits.
    function automatic logic [DATA_W-1:0] fmt_op(input logic [DATA_W-1:0] r,
                                                 input logic [ADDR_W-1:0] src,
                                                 input logic              w64);
        if (!w64 || src == '1)
            return {{HALF{1'b0}}, r[HALF-1:0]};
        return r;
    endfunction

    assign dst_prot = prot_addr(dst_q) ||
                      (is64_q && (prot_addr(dst_q + ADDR_W'(1)) || dst_q == '1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) state_nxt = READ;
            end
            READ:  if (rd_cnt == 2'd0) state_nxt = EXEC;
            EXEC:  if (alu_done) state_nxt = (wr_q && !dst_prot) ? WRITE : IDLE;
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_s0    <= '0;
            rf_s1    <= '0;
            dst_q    <= '0;
            is64_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_cnt   <= 2'd0;
            op_valid <= 1'b0;
            op0      <= '0;
            op1      <= '0;
            rf_w0    <= '0;
            rf_wv    <= '0;
            rf_en_w  <= 1'b0;
            rf_en_64 <= 1'b0;
            wr_fault <= 1'b0;
        end else begin
            rf_en_w  <= 1'b0;
            rf_en_64 <= 1'b0;
            wr_fault <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    rf_s0  <= src0_addr;
                    rf_s1  <= src1_addr;
                    dst_q  <= dst_addr;
                    is64_q <= is_64;
                    wr_q   <= wr_req;
                    rd_cnt <= 2'(READ_LAT);
                end
                READ: begin
                    if (rd_cnt == 2'd0) begin
                        op0      <= fmt_op(rf_r0, rf_s0, is64_q);
                        op1      <= fmt_op(rf_r1, rf_s1, is64_q);
                        op_valid <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                EXEC: if (alu_done) begin
                    op_valid <= 1'b0;
                    if (wr_q) begin
                        if (dst_prot) begin
                            wr_fault <= 1'b1;
                        end else begin
                            rf_w0    <= dst_q;
                            rf_wv    <= is64_q ? alu_result : {{HALF{1'b0}}, alu_result[HALF-1:0]};
                            rf_en_w  <= 1'b1;
                            rf_en_64 <= is64_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_salu_operand_sequencer.sv
// Directed bench for salu_operand_sequencer: READ_LAT=1 instance for function,
// READ_LAT=3 instance for stall/latency behaviour.
module tb_salu_operand_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid, instr_valid_3;
    logic [7:0]  src0_addr, src1_addr, dst_addr;
    logic        is_64, wr_req, alu_done;
    logic [63:0] rf_r0, rf_r1, alu_result;

    logic        instr_ready, op_valid, rf_en_w, rf_en_64, wr_fault, busy;
    logic [7:0]  rf_s0, rf_s1, rf_w0;
    logic [63:0] op0, op1, rf_wv;

    logic        instr_ready_3, op_valid_3, rf_en_w_3, rf_en_64_3, wr_fault_3, busy_3;
    logic [7:0]  rf_s0_3, rf_s1_3, rf_w0_3;
    logic [63:0] op0_3, op1_3, rf_wv_3;

    int n_chk = 0;
    int n_err = 0;

    // results captured by run_instr
    logic [7:0]  o_s0, o_s1, o_w0;
    logic [63:0] o_op0, o_op1, o_wv;
    logic        o_en64, o_ov_after, o_busy;
    int          o_lat, n_w, n_f, o_wpos;

    always #5 clock = ~clock;

    salu_operand_sequencer #(.ADDR_W(8), .DATA_W(64), .READ_LAT(1)) u_dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .src0_addr(src0_addr), .src1_addr(src1_addr), .dst_addr(dst_addr),
        .is_64(is_64), .wr_req(wr_req), .rf_s0(rf_s0), .rf_s1(rf_s1),
        .rf_r0(rf_r0), .rf_r1(rf_r1), .op_valid(op_valid), .op0(op0), .op1(op1),
        .alu_done(alu_done), .alu_result(alu_result), .rf_w0(rf_w0), .rf_wv(rf_wv),
        .rf_en_w(rf_en_w), .rf_en_64(rf_en_64), .wr_fault(wr_fault), .busy(busy)
    );

    salu_operand_sequencer #(.ADDR_W(8), .DATA_W(64), .READ_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid_3), .instr_ready(instr_ready_3),
        .src0_addr(src0_addr), .src1_addr(src1_addr), .dst_addr(dst_addr),
        .is_64(is_64), .wr_req(wr_req), .rf_s0(rf_s0_3), .rf_s1(rf_s1_3),
        .rf_r0(rf_r0), .rf_r1(rf_r1), .op_valid(op_valid_3), .op0(op0_3), .op1(op1_3),
        .alu_done(alu_done), .alu_result(alu_result), .rf_w0(rf_w0_3), .rf_wv(rf_wv_3),
        .rf_en_w(rf_en_w_3), .rf_en_64(rf_en_64_3), .wr_fault(wr_fault_3), .busy(busy_3)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one instruction to the READ_LAT=1 instance and record what it does.
    task automatic run_instr(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] d,
                             input logic w64, input logic wr, input logic [63:0] r0,
                             input logic [63:0] r1, input logic [63:0] res, input int dly);
        src0_addr = s0; src1_addr = s1; dst_addr = d; is_64 = w64; wr_req = wr;
        rf_r0 = r0; rf_r1 = r1; alu_result = res;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        o_s0 = rf_s0; o_s1 = rf_s1;
        o_lat = 0;
        while (!op_valid && o_lat < 20) begin
            tick;
            o_lat++;
        end
        o_op0 = op0; o_op1 = op1;
        repeat (dly) tick;
        alu_done = 1'b1;
        tick;
        alu_done = 1'b0;
        o_ov_after = op_valid;
        n_w = 0; n_f = 0; o_wpos = -1;
        o_w0 = 8'h00; o_wv = 64'h0; o_en64 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rf_en_w) begin
                n_w++; o_w0 = rf_w0; o_wv = rf_wv; o_en64 = rf_en_64;
                if (o_wpos < 0) o_wpos = i;
            end
            if (wr_fault) n_f++;
            tick;
        end
        o_busy = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        n_chk++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if ({op_valid, rf_en_w, rf_en_64, wr_fault} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {op_valid, rf_en_w, rf_en_64, wr_fault}); end
        n_chk++; if ({rf_s0, rf_s1, rf_w0} !== 24'h0) begin n_err++; $display("FAIL reset_addr: got %h want 000000", {rf_s0, rf_s1, rf_w0}); end
        n_chk++; if ({op0, op1, rf_wv} !== 192'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {op0, op1, rf_wv}); end
        n_chk++; if (instr_ready_3 !== 1'b1) begin n_err++; $display("FAIL reset_ready3: got %b want 1", instr_ready_3); end
    endtask

    task automatic test_rw32;
        run_instr(8'h04, 8'h05, 8'h06, 1'b0, 1'b1, 64'h5555_5555_0000_00AA,
                  64'h9999_9999_0000_0033, 64'h1234_5678_0000_0011, 0);
        n_chk++; if ({o_s0, o_s1} !== 16'h0405) begin n_err++; $display("FAIL rw32_raddr: got %h want 0405", {o_s0, o_s1}); end
        n_chk++; if (o_lat !== 2) begin n_err++; $display("FAIL rw32_latency: got %0d want 2", o_lat); end
        n_chk++; if (o_op0 !== 64'h0000_0000_0000_00AA) begin n_err++; $display("FAIL rw32_op0: got %h want 00000000000000aa", o_op0); end
        n_chk++; if (o_op1 !== 64'h0000_0000_0000_0033) begin n_err++; $display("FAIL rw32_op1: got %h want 0000000000000033", o_op1); end
        n_chk++; if (o_ov_after !== 1'b0) begin n_err++; $display("FAIL rw32_opvalid_drop: got %b want 0", o_ov_after); end
        n_chk++; if (n_w !== 1 || o_wpos !== 0) begin n_err++; $display("FAIL rw32_wr_pulse: got cnt %0d pos %0d want 1/0", n_w, o_wpos); end
        n_chk++; if (n_f !== 0) begin n_err++; $display("FAIL rw32_fault: got %0d want 0", n_f); end
        n_chk++; if (o_w0 !== 8'h06) begin n_err++; $display("FAIL rw32_w0: got %h want 06", o_w0); end
        n_chk++; if (o_wv !== 64'h0000_0000_0000_0011) begin n_err++; $display("FAIL rw32_wv: got %h want 0000000000000011", o_wv); end
        n_chk++; if (o_en64 !== 1'b0) begin n_err++; $display("FAIL rw32_en64: got %b want 0", o_en64); end
        n_chk++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rw32_idle: got busy %b want 0", o_busy); end
        n_chk++; if (rf_wv !== 64'h0000_0000_0000_0011 || rf_w0 !== 8'h06) begin n_err++; $display("FAIL rw32_hold: got %h/%h want 06/0000000000000011", rf_w0, rf_wv); end
    endtask

    task automatic test_rw64;
        run_instr(8'h10, 8'h12, 8'h20, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001,
                  64'h0000_0002_0000_0003, 64'hCAFE_F00D_8765_4321, 1);
        n_chk++; if (o_op0 !== 64'hDEAD_BEEF_0000_0001) begin n_err++; $display("FAIL rw64_op0: got %h want deadbeef00000001", o_op0); end
        n_chk++; if (o_op1 !== 64'h0000_0002_0000_0003) begin n_err++; $display("FAIL rw64_op1: got %h want 0000000200000003", o_op1); end
        n_chk++; if (n_w !== 1 || o_en64 !== 1'b1) begin n_err++; $display("FAIL rw64_write: got cnt %0d en64 %b want 1/1", n_w, o_en64); end
        n_chk++; if (o_wv !== 64'hCAFE_F00D_8765_4321) begin n_err++; $display("FAIL rw64_wv: got %h want cafef00d87654321", o_wv); end
        n_chk++; if (o_w0 !== 8'h20) begin n_err++; $display("FAIL rw64_w0: got %h want 20", o_w0); end
    endtask

    task automatic test_protected;
        logic [7:0] dsts [9] = '{8'h7D, 8'hA0, 8'h7C, 8'hFF, 8'h7E, 8'hE9, 8'h7F, 8'hEF, 8'hF9};
        logic       w64s [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       prot [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            run_instr(8'h01, 8'h02, dsts[i], w64s[i], 1'b1, 64'h1, 64'h2, 64'h77, 0);
            n_chk++; if (n_f !== (prot[i] ? 1 : 0) || n_w !== (prot[i] ? 0 : 1)) begin
                n_err++; $display("FAIL prot_dst_%h_w64_%b: got fault %0d write %0d want fault %0d", dsts[i], w64s[i], n_f, n_w, prot[i] ? 1 : 0);
            end
            n_chk++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL prot_idle_%h: got busy %b want 0", dsts[i], o_busy); end
        end
    endtask

    task automatic test_pair_edge;
        run_instr(8'hFF, 8'h10, 8'h30, 1'b1, 1'b0, 64'hDEAD_BEEF_1111_2222,
                  64'h0123_4567_89AB_CDEF, 64'h5, 0);
        n_chk++; if (o_op0 !== 64'h0000_0000_1111_2222) begin n_err++; $display("FAIL pair_op0: got %h want 0000000011112222", o_op0); end
        n_chk++; if (o_op1 !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL pair_op1: got %h want 0123456789abcdef", o_op1); end
        n_chk++; if (n_w !== 0 || n_f !== 0) begin n_err++; $display("FAIL pair_nowrite: got write %0d fault %0d want 0/0", n_w, n_f); end
    endtask

    task automatic test_stall;
        int  k, cnt;
        logic bad;
        src0_addr = 8'h21; src1_addr = 8'h22; dst_addr = 8'h30; is_64 = 1'b0; wr_req = 1'b0;
        rf_r0 = 64'hFFFF_0000_0000_0077; rf_r1 = 64'h0000_0000_0000_0088;
        instr_valid_3 = 1'b1;
        tick;
        // second instruction presented while busy must be ignored
        src0_addr = 8'h40; src1_addr = 8'h41;
        bad = 1'b0; k = 0;
        while (!op_valid_3 && k < 20) begin
            if (instr_ready_3) bad = 1'b1;
            tick;
            k++;
        end
        n_chk++; if (k !== 4) begin n_err++; $display("FAIL stall_latency: got %0d want 4", k); end
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (op_valid_3) cnt++;
            if (instr_ready_3) bad = 1'b1;
            if (i < 4) tick;
        end
        n_chk++; if (cnt !== 5) begin n_err++; $display("FAIL stall_opvalid_hold: got %0d want 5", cnt); end
        n_chk++; if (op0_3 !== 64'h0000_0000_0000_0077) begin n_err++; $display("FAIL stall_op0: got %h want 0000000000000077", op0_3); end
        instr_valid_3 = 1'b0;
        alu_done = 1'b1;
        tick;
        alu_done = 1'b0;
        n_chk++; if (bad !== 1'b0) begin n_err++; $display("FAIL stall_ready_low: got ready seen %b want 0", bad); end
        n_chk++; if (op_valid_3 !== 1'b0 || busy_3 !== 1'b0) begin n_err++; $display("FAIL stall_done: got op_valid %b busy %b want 0/0", op_valid_3, busy_3); end
        tick;
        n_chk++; if (busy_3 !== 1'b0 || rf_s0_3 !== 8'h21) begin n_err++; $display("FAIL stall_ignored: got busy %b s0 %h want 0/21", busy_3, rf_s0_3); end
    endtask

    task automatic test_reset_mid;
        int  k;
        logic seen;
        src0_addr = 8'h04; src1_addr = 8'h05; dst_addr = 8'h06; is_64 = 1'b0; wr_req = 1'b1;
        rf_r0 = 64'hAA; rf_r1 = 64'hBB; alu_result = 64'h99;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        k = 0;
        while (!op_valid && k < 20) begin tick; k++; end
        n_chk++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_exec: got op_valid %b want 1", op_valid); end
        reset = 1'b1; alu_done = 1'b1;
        tick;
        reset = 1'b0; alu_done = 1'b0;
        n_chk++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got ready %b busy %b want 1/0", instr_ready, busy); end
        n_chk++; if ({op_valid, rf_en_w, rf_en_64, wr_fault} !== 4'b0) begin n_err++; $display("FAIL rstmid_flags: got %b want 0000", {op_valid, rf_en_w, rf_en_64, wr_fault}); end
        n_chk++; if ({rf_s0, rf_s1, rf_w0} !== 24'h0 || {op0, op1, rf_wv} !== 192'h0) begin n_err++; $display("FAIL rstmid_zero: got %h %h want 0", {rf_s0, rf_s1, rf_w0}, {op0, op1, rf_wv}); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rf_en_w || wr_fault) seen = 1'b1;
            tick;
        end
        n_chk++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_nowrite: got write/fault %b want 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_valid_3 = 1'b0;
        src0_addr = '0; src1_addr = '0; dst_addr = '0; is_64 = 1'b0; wr_req = 1'b0;
        rf_r0 = '0; rf_r1 = '0; alu_done = 1'b0; alu_result = '0;
        test_reset;
        test_rw32;
        test_rw64;
        test_protected;
        test_pair_edge;
        test_stall;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/salu_operand_sequencer.md
Name: salu_operand_sequencer

Overview:
Control-side counterpart to the scalar register file. It accepts one decoded scalar instruction at a time and drives the register file read addresses (s0/s1). It captures the returned operands and hands them to the SALU with a valid/done handshake, then drives the register file write port (w0/wv/en_w/en_64) with the result. Writes to read-only SGPR addresses are blocked here and flagged, so the register file only ever receives legal writes.

Parameters:
ADDR_W, 8, SGPR address width
DATA_W, 64, operand/result width (two 32-bit SGPRs)
READ_LAT, 1, cycles from driving rf_s0/rf_s1 to valid rf_r0/rf_r1 (range 1-3)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  sequencer can accept an instruction
src0_addr  in  8  source 0 SGPR index
src1_addr  in  8  source 1 SGPR index
dst_addr  in  8  destination SGPR index
is_64  in  1  64-bit operands/result (SGPR pair)
wr_req  in  1  instruction writes dst
rf_s0  out  8  register file read address 0
rf_s1  out  8  register file read address 1
rf_r0  in  64  register file read data 0 ({hi,lo})
rf_r1  in  64  register file read data 1
op_valid  out  1  operands valid to SALU
op0  out  64  operand 0
op1  out  64  operand 1
alu_done  in  1  SALU result valid, single-cycle pulse
alu_result  in  64  SALU result
rf_w0  out  8  write address
rf_wv  out  64  write data
rf_en_w  out  1  write enable, one-cycle pulse
rf_en_64  out  1  64-bit write qualifier
wr_fault  out  1  one-cycle pulse when a write was suppressed
busy  out  1  sequencer not in IDLE

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - state goes to IDLE.
  - All outputs go to 0 except instr_ready, which is 1.
  - Reset during any state aborts the instruction. No rf_en_w is issued and no wr_fault is raised.
- States are IDLE, READ, EXEC and WRITE.
- IDLE:
  - instr_ready=1, busy=0.
  - On instr_valid: latch src0/src1/dst/is_64/wr_req, drive rf_s0=src0_addr and rf_s1=src1_addr, load the read counter with READ_LAT, and go to READ.
- READ:
  - rf_s0/rf_s1 are held stable.
  - The counter decrements each cycle. When it reaches 0, sample rf_r0/rf_r1 on that edge and go to EXEC.
  - Sampling: if is_64=0, op0/op1 = {32'h0, r[31:0]}.
  - If is_64=1 and the source address is 8'hFF, the pair has no upper register. The upper half of that operand is forced to 32'h0.
- EXEC:
  - op_valid=1; op0/op1 are held stable.
  - alu_done is sampled only in EXEC and ignored in all other states.
  - On alu_done, op_valid drops on the next edge.
  - If wr_req=0: go to IDLE.
  - If wr_req=1 and the destination is protected: pulse wr_fault and go to IDLE.
  - Otherwise: latch the result and go to WRITE.
- Protected destination (write suppressed):
  - dst is 8'h7D, in 8'h80-8'hE8, or in 8'hF0-8'hF8.
  - If is_64=1, the address is also protected when dst+1 falls in any of those ranges, or when dst is 8'hFF (pair would wrap).
- WRITE:
  - Exactly one cycle with rf_en_w=1, rf_w0=dst and rf_en_64=is_64.
  - rf_wv=alu_result if is_64, else {32'h0, alu_result[31:0]}.
  - Then go to IDLE. rf_en_w/rf_en_64 return to 0 and rf_w0/rf_wv hold their last value.
- Latency (READ_LAT=1, alu_done returned the cycle after op_valid):
  - accept at edge 0;
  - op_valid high from edge 2;
  - rf_en_w pulse in the cycle after alu_done;
  - next accept no earlier than the cycle after WRITE.
- No pipelining: one instruction in flight, so there are no read-after-write hazards.
- instr_valid while instr_ready=0 is ignored. Upstream holds the instruction until instr_ready.

Test Plan:
- 32-bit read/write: src0=8'h04 (lo=32'h0000_00AA), src1=8'h05, dst=8'h06, wr_req=1, alu_result=64'h1234_5678_0000_0011 -> op0=64'h0000_0000_0000_00AA; rf_en_w one cycle, rf_w0=8'h06, rf_wv=64'h0000_0000_0000_0011, rf_en_64=0.
- 64-bit: src0=8'h10, is_64=1, rf_r0=64'hDEAD_BEEF_0000_0001, dst=8'h20 -> op0=64'hDEAD_BEEF_0000_0001; rf_en_64=1, rf_wv=alu_result unmodified.
- Protected write: dst=8'h7D; then dst=8'hA0; then dst=8'h7C with is_64=1 (7D protected) -> each gives wr_fault one-cycle pulse, rf_en_w never asserted, return to IDLE.
- Pair edge: src0=8'hFF, is_64=1 -> op0[63:32]=0. dst=8'hFF, is_64=1 -> wr_fault pulse, no write.
- Stall and latency: READ_LAT=3, alu_done delayed 5 cycles -> op_valid rises exactly 4 cycles after accept and holds 5 cycles. instr_ready=0 throughout, and a second instr_valid is ignored.
- Reset mid-op: assert reset in EXEC with a pending write to 8'h06 -> next cycle all outputs 0, instr_ready=1, no rf_en_w ever issued.
